// File: rtl/rr_ctz_arbiter_pkg.sv
// Shared types and elaboration helpers for the round-robin CTZ arbiter.
package rr_ctz_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Hold counter must reach TIMEOUT-1; keep at least one bit when TIMEOUT is 0.
    function automatic int cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/rr_ctz_arbiter_if.sv
// Requester-side bus of the arbiter: request/release in, grant status out.
interface rr_ctz_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic           rel;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           timeout;

    modport master (
        output req,
        output rel,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  timeout
    );

    modport slave (
        input  req,
        input  rel,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output timeout
    );

endinterface

// File: rtl/rr_ctz_arbiter_ctz.sv
// Combinational trailing-zero count; an all-zero input yields W (no winner).
module ctz_core #(
    parameter int W = 4
) (
    input  logic [W-1:0]        i_vec,
    output logic [$clog2(W):0]  o_cnt
);
    localparam int OW = $clog2(W) + 1;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        o_cnt = OW'(W);
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_cnt = OW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_ctz_arbiter.sv
// Round-robin arbiter: grant held until release or hold timeout, winner picked
// by trailing-zero count of requests strictly above the last grantee.
module rr_ctz_arbiter
    import rr_ctz_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            resetn,
    rr_ctz_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N);
    localparam int CTW = IDW + 1;
    localparam int HCW = cnt_width(TIMEOUT);
    localparam logic [CTW-1:0] NO_WIN = CTW'(N);

    arb_state_t     r_state;
    logic [IDW-1:0] r_ptr;
    logic [HCW-1:0] r_hold_cnt;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_gnt_id;
    logic           r_timeout;

    arb_state_t     w_state_next;
    logic [IDW-1:0] w_ptr_next;
    logic [HCW-1:0] w_hold_next;
    logic [N-1:0]   w_gnt_next;
    logic [IDW-1:0] w_gnt_id_next;
    logic           w_timeout_next;

    logic [IDW-1:0] w_base;
    logic [N-1:0]   w_above;
    logic [N-1:0]   w_masked;
    logic [CTW-1:0] w_masked_cnt;
    logic [CTW-1:0] w_raw_cnt;
    logic           w_any_req;
    logic [IDW-1:0] w_win_id;
    logic [N-1:0]   w_win_onehot;
    logic           w_expire;
    logic           w_release;

    // While granting, the pointer is about to become the current holder.
    assign w_base = (r_state == ARB_GRANT) ? r_gnt_id : r_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign w_above[gi]      = (IDW'(gi) > w_base);
            assign w_win_onehot[gi] = w_any_req && (w_win_id == IDW'(gi));
        end
    endgenerate

    assign w_masked = bus.req & w_above;

    ctz_core #(.W(N)) u_ctz_masked (
        .i_vec (w_masked),
        .o_cnt (w_masked_cnt)
    );

    ctz_core #(.W(N)) u_ctz_raw (
        .i_vec (bus.req),
        .o_cnt (w_raw_cnt)
    );

    assign w_any_req = (w_raw_cnt != NO_WIN);
    assign w_win_id  = (w_masked_cnt != NO_WIN) ? w_masked_cnt[IDW-1:0]
                                                : w_raw_cnt[IDW-1:0];

    generate
        if (TIMEOUT != 0) begin : g_timeout
            assign w_expire = (r_state == ARB_GRANT) &&
                              (r_hold_cnt == HCW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end
    endgenerate

    assign w_release = (r_state == ARB_GRANT) && (bus.rel || w_expire);

    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_hold_next    = r_hold_cnt;
        w_gnt_next     = r_gnt;
        w_gnt_id_next  = r_gnt_id;
        w_timeout_next = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    w_state_next  = ARB_GRANT;
                    w_gnt_next    = w_win_onehot;
                    w_gnt_id_next = w_win_id;
                    w_hold_next   = '0;
                end
            end
            ARB_GRANT: begin
                if (TIMEOUT != 0) begin
                    w_hold_next = r_hold_cnt + 1'b1;
                end
                if (w_release) begin
                    w_ptr_next     = r_gnt_id;
                    w_hold_next    = '0;
                    // An explicit release in the expiry cycle is not a forced one.
                    w_timeout_next = w_expire && !bus.rel;
                    if (w_any_req) begin
                        w_gnt_next    = w_win_onehot;
                        w_gnt_id_next = w_win_id;
                    end else begin
                        w_state_next  = ARB_IDLE;
                        w_gnt_next    = '0;
                        w_gnt_id_next = '0;
                    end
                end
            end
            default: begin
                w_state_next  = ARB_IDLE;
                w_gnt_next    = '0;
                w_gnt_id_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= IDW'(N - 1);
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_hold_cnt <= w_hold_next;
            r_gnt      <= w_gnt_next;
            r_gnt_id   <= w_gnt_id_next;
            r_timeout  <= w_timeout_next;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_valid = |r_gnt;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_ctz_arbiter.sv
// Bench for rr_ctz_arbiter: three configurations driven in parallel and
// compared every cycle against a rotating-search reference model.
module tb_rr_ctz_arbiter;

    localparam int NK = 3;

    logic       clk;
    logic       resetn;
    logic [4:0] req_drv;
    logic       rel_drv;

    int n_cmp;
    int n_mis;

    int NN[NK] = '{4, 4, 5};
    int TT[NK] = '{0, 4, 3};

    int m_holder[NK];
    int m_ptr[NK];
    int m_held[NK];
    bit m_to[NK];

    rr_ctz_arbiter_if #(.N(4)) bus0 ();
    rr_ctz_arbiter_if #(.N(4)) bus1 ();
    rr_ctz_arbiter_if #(.N(5)) bus2 ();

    assign bus0.req = req_drv[3:0];
    assign bus1.req = req_drv[3:0];
    assign bus2.req = req_drv;
    assign bus0.rel = rel_drv;
    assign bus1.rel = rel_drv;
    assign bus2.rel = rel_drv;

    rr_ctz_arbiter #(.N(4), .TIMEOUT(0)) u_dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
    rr_ctz_arbiter #(.N(4), .TIMEOUT(4)) u_dut1 (.clk(clk), .resetn(resetn), .bus(bus1));
    rr_ctz_arbiter #(.N(5), .TIMEOUT(3)) u_dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: got no finish, required finish before 500us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_gnt(input int k);
        case (k)
            0: return 32'(bus0.gnt);
            1: return 32'(bus1.gnt);
            default: return 32'(bus2.gnt);
        endcase
    endfunction

    function automatic logic [31:0] obs_valid(input int k);
        case (k)
            0: return 32'(bus0.gnt_valid);
            1: return 32'(bus1.gnt_valid);
            default: return 32'(bus2.gnt_valid);
        endcase
    endfunction

    function automatic logic [31:0] obs_id(input int k);
        case (k)
            0: return 32'(bus0.gnt_id);
            1: return 32'(bus1.gnt_id);
            default: return 32'(bus2.gnt_id);
        endcase
    endfunction

    function automatic logic [31:0] obs_to(input int k);
        case (k)
            0: return 32'(bus0.timeout);
            1: return 32'(bus1.timeout);
            default: return 32'(bus2.timeout);
        endcase
    endfunction

    // Next requester found by walking round the ring starting just after ptr.
    function automatic int winner(input int r, input int n, input int ptr);
        for (int d = 1; d <= n; d++) begin
            int i;
            i = (ptr + d) % n;
            if (((r >> i) & 1) != 0) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            m_holder[k] = -1;
            m_ptr[k]    = NN[k] - 1;
            m_held[k]   = 0;
            m_to[k]     = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NK; k++) begin
            int  r;
            bit  expire;
            bit  granted;
            r = int'(req_drv) & ((1 << NN[k]) - 1);
            m_to[k] = 1'b0;
            granted = 1'b0;
            if (m_holder[k] < 0) begin
                if (r != 0) begin
                    m_holder[k] = winner(r, NN[k], m_ptr[k]);
                    m_held[k]   = 1;
                    granted     = 1'b1;
                end
            end else begin
                expire = (TT[k] != 0) && (m_held[k] == TT[k]);
                if (rel_drv || expire) begin
                    m_ptr[k]    = m_holder[k];
                    m_to[k]     = expire && !rel_drv;
                    m_holder[k] = winner(r, NN[k], m_holder[k]);
                    m_held[k]   = (m_holder[k] >= 0) ? 1 : 0;
                    granted     = (m_holder[k] >= 0);
                end else begin
                    m_held[k]++;
                end
            end
            if (granted)
                $display("t=%0t dut%0d req=%b rel=%0d -> grant id=%0d%s", $time, k,
                         req_drv, rel_drv, m_holder[k], m_to[k] ? " (after timeout)" : "");
        end
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < NK; k++) begin
            logic [31:0] eg;
            logic [31:0] g;
            eg = (m_holder[k] < 0) ? 32'd0 : (32'd1 << m_holder[k]);
            g  = obs_gnt(k);
            check($sformatf("%s.d%0d.gnt", tag, k), g, eg);
            check($sformatf("%s.d%0d.valid", tag, k), obs_valid(k), 32'(m_holder[k] >= 0));
            check($sformatf("%s.d%0d.id", tag, k), obs_id(k),
                  (m_holder[k] < 0) ? 32'd0 : 32'(m_holder[k]));
            check($sformatf("%s.d%0d.timeout", tag, k), obs_to(k), 32'(m_to[k]));
            check($sformatf("%s.d%0d.onehot0", tag, k), 32'($onehot0(g)), 32'd1);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        resetn = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int seq[5];
        n_cmp   = 0;
        n_mis   = 0;
        req_drv = '0;
        rel_drv = 1'b0;
        resetn  = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Idle, then first grant goes to the lowest requester.
        repeat (10) tick("t1.idle");
        req_drv = 5'b00110;
        tick("t1.first");
        check("t1.gnt_lit", obs_gnt(0), 32'b0010);
        check("t1.id_lit", obs_id(0), 32'd1);

        // Full rotation with back-to-back grants.
        do_reset("t2.rst");
        seq = '{0, 1, 2, 3, 0};
        req_drv = 5'b01111;
        rel_drv = 1'b0;
        tick("t2.g0");
        check("t2.id0_lit", obs_id(0), 32'(seq[0]));
        rel_drv = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick("t2.rot");
            check($sformatf("t2.id%0d_lit", i), obs_id(0), 32'(seq[i]));
            check($sformatf("t2.valid%0d_lit", i), obs_valid(0), 32'd1);
        end

        // Skip over a non-requester, then wrap.
        do_reset("t3.rst");
        req_drv = 5'b00010;
        rel_drv = 1'b0;
        tick("t3.g1");
        req_drv = 5'b01011;
        rel_drv = 1'b1;
        tick("t3.g3");
        check("t3.id3_lit", obs_id(0), 32'd3);
        tick("t3.wrap");
        check("t3.wrap_lit", obs_id(0), 32'd0);

        // Hold timeout on the TIMEOUT=4 instance, then rel winning the tie.
        do_reset("t4.rst");
        req_drv = 5'b00011;
        rel_drv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick("t4.hold0");
            check("t4.hold0_lit", obs_id(1), 32'd0);
        end
        tick("t4.expire");
        check("t4.to_lit", obs_to(1), 32'd1);
        check("t4.id1_lit", obs_id(1), 32'd1);
        repeat (3) tick("t4.hold1");
        rel_drv = 1'b1;
        tick("t4.tie");
        check("t4.tie_to_lit", obs_to(1), 32'd0);
        check("t4.tie_id_lit", obs_id(1), 32'd0);
        rel_drv = 1'b0;

        // Asynchronous reset while id2 holds the grant.
        do_reset("t5.rst");
        req_drv = 5'b00100;
        tick("t5.g2");
        tick("t5.hold");
        resetn = 1'b0;
        model_reset();
        #1;
        check("t5.async_gnt_lit", obs_gnt(0), 32'd0);
        compare_all("t5.async");
        @(negedge clk);
        resetn  = 1'b1;
        req_drv = 5'b01001;
        tick("t5.after");
        check("t5.id0_lit", obs_id(0), 32'd0);

        // Lone requester re-granted every cycle without dropping valid.
        do_reset("t6.rst");
        req_drv = 5'b00100;
        rel_drv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick("t6.lone");
            check("t6.id_lit", obs_id(0), 32'd2);
            check("t6.valid_lit", obs_valid(0), 32'd1);
        end
        rel_drv = 1'b0;

        // Random traffic with occasional resets.
        for (int c = 0; c < 500; c++) begin
            req_drv = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) req_drv = '0;
            rel_drv = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0)
                do_reset("rand.rst");
            else
                tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
